// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment scan controller.
//   SEG_OFF / AN_OFF : all-dark segment and anode patterns (active-low).
//   NDIG             : number of scanned digits.
//   SEG_GLYPH        : hex glyphs 0..F, active-low, bit 6 = A .. bit 0 = G.
//   disp_t           : one registered display sample (anodes, segments, dp).
package seg_pkg;

  localparam int          NDIG    = 4;
  localparam logic [6:0]  SEG_OFF = 7'b1111111;
  localparam logic [3:0]  AN_OFF  = 4'b1111;

  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seven;
    logic       dp;
  } disp_t;

  localparam disp_t DISP_OFF = '{an: AN_OFF, seven: SEG_OFF, dp: 1'b1};

endpackage

// File: rtl/binary_to_segment.sv
// binary_to_segment: combinational hex-nibble to 7-segment decoder.
//   bin : 4-bit nibble in.
//   seg : active-low segments out, bit 6 = A .. bit 0 = G.
module binary_to_segment
  import seg_pkg::*;
(
  input  logic [3:0] bin,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[bin];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit
// common-anode 7-segment display with a frame-aligned load/ack handshake.
//   clk, rst_n   : clock, async active-low reset.
//   value_in     : four hex nibbles, [3:0] = digit 0 (rightmost).
//   dp_in        : decimal-point request per digit.
//   digit_en     : live per-digit enable.
//   lzb          : live leading-zero blanking enable.
//   load         : capture request for value_in/dp_in.
//   load_ack     : pulse when a captured value becomes visible.
//   an/seven/dp  : registered active-low display drive.
//   frame_start  : pulse on the output cycle of digit 0, slot count 0.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        lzb,
  input  logic        load,
  output logic        load_ack,
  output logic [3:0]  an,
  output logic [6:0]  seven,
  output logic        dp,
  output logic        frame_start
);

  localparam int            CW       = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ON   = CW'(DIV - BLANK);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [15:0]   pend_q, pend_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_valid_q, pend_valid_d;
  logic          load_ack_q, load_ack_d;
  logic          frame_start_q, frame_start_d;
  disp_t         disp_q, disp_d;

  logic          slot_end, commit, lz_blank, lit;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  assign nib = shadow_q[{idx_q, 2'b00} +: 4];

  binary_to_segment u_dec (
    .bin (nib),
    .seg (glyph)
  );

  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    // The commit cycle always falls in the blanking tail of digit 3,
    // so swapping the shadow here never shows a torn value.
    commit   = slot_end && (idx_q == 2'(NDIG - 1));

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = slot_end ? idx_q + 2'd1 : idx_q;

    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    load_ack_d   = 1'b0;

    if (commit) begin
      // A load landing on the commit cycle supersedes any pending value;
      // either way exactly one ack follows.
      if (load) begin
        shadow_d     = value_in;
        shadow_dp_d  = dp_in;
        pend_valid_d = 1'b0;
        load_ack_d   = 1'b1;
      end else if (pend_valid_q) begin
        shadow_d     = pend_q;
        shadow_dp_d  = pend_dp_q;
        pend_valid_d = 1'b0;
        load_ack_d   = 1'b1;
      end
    end else if (load) begin
      pend_d       = value_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end

    unique case (idx_q)
      2'd3:    lz_blank = (shadow_q[15:12] == 4'h0);
      2'd2:    lz_blank = (shadow_q[15:8]  == 8'h00);
      2'd1:    lz_blank = (shadow_q[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase

    lit = (cnt_q < CNT_ON) && digit_en[idx_q] && !(lzb && lz_blank);

    disp_d = DISP_OFF;
    if (lit) begin
      disp_d.an    = ~(4'b0001 << idx_q);
      disp_d.seven = glyph;
      disp_d.dp    = ~shadow_dp_q[idx_q];
    end

    frame_start_d = (cnt_q == '0) && (idx_q == 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      shadow_q      <= 16'h0000;
      shadow_dp_q   <= 4'h0;
      pend_q        <= 16'h0000;
      pend_dp_q     <= 4'h0;
      pend_valid_q  <= 1'b0;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      disp_q        <= DISP_OFF;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      shadow_dp_q   <= shadow_dp_d;
      pend_q        <= pend_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
      disp_q        <= disp_d;
    end
  end

  assign an          = disp_q.an;
  assign seven       = disp_q.seven;
  assign dp          = disp_q.dp;
  assign load_ack    = load_ack_q;
  assign frame_start = frame_start_q;

endmodule
